// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode, funct, ALU and fault encodings for the multicycle controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    WB_ALU,
    MEM_ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    BRANCH,
    JUMP,
    HALT,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_OPCODE  = 2'b01,
    FAULT_FUNCT   = 2'b10,
    FAULT_TIMEOUT = 2'b11
  } fault_t;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SUB = 3'd6;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRC_B_RT       = 2'b00;
  localparam logic [1:0] SRC_B_FOUR     = 2'b01;
  localparam logic [1:0] SRC_B_IMM      = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

  // States that hold mem_req and therefore run the wait counter
  function automatic logic is_mem_wait(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - R-type funct to ALU operation decode with legality flag
import ctrl_pkg::*;

module alu_decoder #(
  parameter int ALU_OP_WIDTH = 3
) (
  input  logic [5:0]              funct,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    legal
);

  // Map supported funct codes to ALU ops; anything else is flagged illegal
  always_comb begin
    alu_op = ALU_OP_WIDTH'(ALU_ADD);
    legal  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_OP_WIDTH'(ALU_ADD);
      FN_SUB:  alu_op = ALU_OP_WIDTH'(ALU_SUB);
      FN_AND:  alu_op = ALU_OP_WIDTH'(ALU_AND);
      FN_OR:   alu_op = ALU_OP_WIDTH'(ALU_OR);
      FN_SLT:  alu_op = ALU_OP_WIDTH'(ALU_SLT);
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS-subset control FSM with memory handshake and faults
import ctrl_pkg::*;

module multicycle_controller #(
  parameter int ALU_OP_WIDTH = 3,
  parameter int CNT_WIDTH    = 32,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             instruction,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    i_or_d,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic [1:0]              pc_src,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic                    reg_write,
  output logic                    reg_dst,
  output logic                    mem_reg,
  output logic                    halted,
  output logic [1:0]              fault,
  output logic [CNT_WIDTH-1:0]    instr_retired
);

  // Counter only needs to reach MEM_TIMEOUT-1
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t                state;
  state_t                next_state;
  fault_t                fault_q;
  fault_t                next_fault;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [CNT_WIDTH-1:0]  retired_q;
  logic                  timed_out;
  logic                  retire;

  logic [5:0]              opcode;
  logic [5:0]              funct;
  logic [ALU_OP_WIDTH-1:0] dec_alu_op;
  logic                    funct_legal;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  // Register/immediate fields belong to the datapath, not to control
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[25:6];

  alu_decoder #(
    .ALU_OP_WIDTH(ALU_OP_WIDTH)
  ) u_alu_decoder (
    .funct (funct),
    .alu_op(dec_alu_op),
    .legal (funct_legal)
  );

  // Final wait cycle without mem_ready expires the request; mem_ready on that cycle still wins
  assign timed_out = TIMEOUT_EN && (wait_cnt == WAIT_LAST) && !mem_ready;

  // Next-state and fault selection
  always_comb begin
    next_state = state;
    next_fault = fault_q;
    case (state)
      FETCH: begin
        if (mem_ready) begin
          next_state = DECODE;
        end else if (timed_out) begin
          next_state = ERROR;
          next_fault = FAULT_TIMEOUT;
        end
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct_legal) begin
              next_state = EXEC_R;
            end else begin
              next_state = ERROR;
              next_fault = FAULT_FUNCT;
            end
          end
          OP_ADDI:      next_state = EXEC_I;
          OP_LW, OP_SW: next_state = MEM_ADDR;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          OP_HALT:      next_state = HALT;
          default: begin
            next_state = ERROR;
            next_fault = FAULT_OPCODE;
          end
        endcase
      end
      EXEC_R, EXEC_I:               next_state = WB_ALU;
      WB_ALU, WB_MEM, BRANCH, JUMP: next_state = FETCH;
      MEM_ADDR: next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready) begin
          next_state = WB_MEM;
        end else if (timed_out) begin
          next_state = ERROR;
          next_fault = FAULT_TIMEOUT;
        end
      end
      MEM_WR: begin
        if (mem_ready) begin
          next_state = FETCH;
        end else if (timed_out) begin
          next_state = ERROR;
          next_fault = FAULT_TIMEOUT;
        end
      end
      HALT, ERROR: next_state = state;
      default:     next_state = FETCH;
    endcase
  end

  // An instruction retires when its last state hands back to FETCH
  always_comb begin
    retire = 1'b0;
    if (next_state == FETCH) begin
      case (state)
        WB_ALU, WB_MEM, MEM_WR, BRANCH, JUMP: retire = 1'b1;
        default:                              retire = 1'b0;
      endcase
    end
  end

  // State, fault latch, wait counter and retired counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      fault_q   <= FAULT_NONE;
      wait_cnt  <= '0;
      retired_q <= '0;
    end else begin
      state   <= next_state;
      fault_q <= next_fault;
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (is_mem_wait(state)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (retire) begin
        retired_q <= retired_q + CNT_WIDTH'(1);
      end
    end
  end

  // Control word per state; everything is held low while reset is asserted
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_op        = ALU_OP_WIDTH'(ALU_ADD);
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_RT;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_reg       = 1'b0;
    halted        = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRC_B_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_ALU;
          end
        end
        DECODE: begin
          alu_src_b = SRC_B_IMM_SHL2;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_RT;
          alu_op    = dec_alu_op;
        end
        EXEC_I, MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
        end
        WB_ALU: begin
          reg_write = 1'b1;
          reg_dst   = (opcode == OP_RTYPE);
        end
        MEM_RD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        WB_MEM: begin
          reg_write = 1'b1;
          mem_reg   = 1'b1;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRC_B_RT;
          alu_op        = ALU_OP_WIDTH'(ALU_SUB);
          pc_write_cond = 1'b1;
          pc_src        = PC_SRC_ALU_OUT;
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
        end
        HALT, ERROR: begin
          halted = 1'b1;
        end
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

  assign fault         = fault_q;
  assign instr_retired = retired_q;

endmodule
